// File: rtl/lfsr_mux_reg.sv
// -----------------------------------------------------------------------------
// lfsr_mux_reg
//
// Registered Fibonacci LFSR with a per-bit 2:1 select (parallel seed on load,
// shifted feedback on step). Besides the state register it tracks the number
// of steps since the last load or wrap, measures the cycle period (steps
// until the state returns to the loaded seed) and detects the all-zero
// lock-up state.
//
// Parameters:
//   WIDTH   - LFSR state width (>= 3)
//   TAPS    - feedback tap mask; bit i set XORs q[i] into the feedback bit
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - synchronous, active-high reset
//   load    - capture seed into state (priority over en)
//   en      - advance the LFSR one step (RUN state only)
//   seed    - parallel load value
//   q       - current LFSR state (registered)
//   fb      - combinational feedback bit, ^(q & TAPS)
//   running - high in RUN state
//   lockup  - high in LOCK state (all-zero state)
//   wrap    - registered one-cycle pulse: state returned to loaded seed
//   steps   - steps taken since last load or wrap (mod 2^WIDTH)
//   period  - last measured period, 0 until the first wrap
// -----------------------------------------------------------------------------
module lfsr_mux_reg #(
  parameter int unsigned         WIDTH = 4,
  parameter logic [WIDTH-1:0]    TAPS  = 4'b1001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] q,
  output logic             fb,
  output logic             running,
  output logic             lockup,
  output logic             wrap,
  output logic [WIDTH-1:0] steps,
  output logic [WIDTH-1:0] period
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_seed;
  logic [WIDTH-1:0] r_steps;
  logic [WIDTH-1:0] r_period;
  logic             r_wrap;

  logic             w_fb;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_d;
  logic             w_step;
  logic             w_hit;

  // Feedback and shift-left step function
  assign w_fb     = ^(r_q & TAPS);
  assign w_q_next = {r_q[WIDTH-2:0], w_fb};

  // Per-bit 2:1 select: seed on load, shifted feedback otherwise
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mux
    assign w_d[gi] = load ? seed[gi] : w_q_next[gi];
  end

  // A step happens only in RUN without a competing load
  assign w_step = (r_state == S_RUN) && en && !load;
  assign w_hit  = (w_q_next == r_seed);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (load) begin
      w_state_next = (seed != '0) ? S_RUN : S_LOCK;
    end else begin
      unique case (r_state)
        S_IDLE: w_state_next = S_IDLE;
        // A non-maximal tap mask can shift a nonzero state into all-zero;
        // that is a lock-up just like loading a zero seed.
        S_RUN:  w_state_next = (en && (w_q_next == '0)) ? S_LOCK : S_RUN;
        S_LOCK: w_state_next = S_LOCK;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    running = 1'b0;
    lockup  = 1'b0;
    unique case (r_state)
      S_RUN:   running = 1'b1;
      S_LOCK:  lockup  = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: state, seed, step counter, period, wrap pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q      <= '0;
      r_seed   <= '0;
      r_steps  <= '0;
      r_period <= '0;
      r_wrap   <= 1'b0;
    end else if (load) begin
      r_q     <= w_d;
      r_seed  <= seed;
      r_steps <= '0;
      r_wrap  <= 1'b0;
    end else if (w_step) begin
      r_q <= w_d;
      if (w_hit) begin
        r_wrap   <= 1'b1;
        r_period <= r_steps + ONE;
        r_steps  <= '0;
      end else begin
        r_wrap  <= 1'b0;
        r_steps <= r_steps + ONE;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign q      = r_q;
  assign fb     = w_fb;
  assign wrap   = r_wrap;
  assign steps  = r_steps;
  assign period = r_period;

endmodule

// File: tb/tb_lfsr_mux_reg.sv
// -----------------------------------------------------------------------------
// tb_lfsr_mux_reg
//
// Directed self-checking bench for lfsr_mux_reg (WIDTH=4, TAPS=4'b1001).
// Expected values are hand-computed from x^4+x^3+1 stepping, shift left.
// -----------------------------------------------------------------------------
module tb_lfsr_mux_reg;

  logic       clk;
  logic       rst;
  logic       load;
  logic       en;
  logic [3:0] seed;
  logic [3:0] q;
  logic       fb;
  logic       running;
  logic       lockup;
  logic       wrap;
  logic [3:0] steps;
  logic [3:0] period;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected trajectory from seed 4'b0001
  logic [3:0] exp_seq [15] = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1101,
                               4'b1010, 4'b0101, 4'b1011, 4'b0110, 4'b1100,
                               4'b1001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  lfsr_mux_reg #(
    .WIDTH (4),
    .TAPS  (4'b1001)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .en      (en),
    .seed    (seed),
    .q       (q),
    .fb      (fb),
    .running (running),
    .lockup  (lockup),
    .wrap    (wrap),
    .steps   (steps),
    .period  (period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs changed 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with load asserted: reset must win
    rst  = 1'b1;
    load = 1'b1;
    en   = 1'b0;
    seed = 4'b0101;
    tick();
    tick();
    chk("rst_q",       32'(q),       32'h0);
    chk("rst_steps",   32'(steps),   32'h0);
    chk("rst_period",  32'(period),  32'h0);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_lockup",  32'(lockup),  32'h0);
    chk("rst_wrap",    32'(wrap),    32'h0);

    // Load seed 0001
    rst  = 1'b0;
    load = 1'b1;
    seed = 4'b0001;
    tick();
    chk("load_q",       32'(q),       32'h1);
    chk("load_running", 32'(running), 32'h1);
    chk("load_steps",   32'(steps),   32'h0);
    chk("fb_0001",      32'(fb),      32'h1);

    // Full sequence of 15 steps
    load = 1'b0;
    en   = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk($sformatf("seq_q_%0d", k), 32'(q), 32'(exp_seq[k-1]));
      if (k < 15) begin
        chk($sformatf("seq_steps_%0d", k), 32'(steps), 32'(k));
        chk($sformatf("seq_wrap_%0d", k),  32'(wrap),  32'h0);
        chk($sformatf("seq_period_%0d", k), 32'(period), 32'h0);
      end else begin
        chk("wrap_pulse",  32'(wrap),   32'h1);
        chk("wrap_period", 32'(period), 32'd15);
        chk("wrap_steps",  32'(steps),  32'h0);
      end
    end

    // Wrap lasts exactly one cycle
    tick();
    chk("post_wrap_q",      32'(q),      32'h3);
    chk("post_wrap_wrap",   32'(wrap),   32'h0);
    chk("post_wrap_steps",  32'(steps),  32'h1);
    chk("post_wrap_period", 32'(period), 32'd15);

    // Step on to 1110 (0111, 1111, 1110)
    tick();
    tick();
    tick();
    chk("pre_hold_q",     32'(q),     32'hE);
    chk("pre_hold_steps", 32'(steps), 32'h4);
    chk("fb_1110",        32'(fb),    32'h1);

    // Hold for 3 cycles
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_q",      32'(q),      32'hE);
      chk("hold_steps",  32'(steps),  32'h4);
      chk("hold_period", 32'(period), 32'd15);
      chk("hold_wrap",   32'(wrap),   32'h0);
    end

    // Lock-up: load zero seed
    load = 1'b1;
    seed = 4'b0000;
    tick();
    load = 1'b0;
    chk("lock_lockup",  32'(lockup),  32'h1);
    chk("lock_running", 32'(running), 32'h0);
    chk("lock_q",       32'(q),       32'h0);
    chk("lock_period",  32'(period),  32'd15);
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("lock_hold_q",      32'(q),      32'h0);
      chk("lock_hold_lockup", 32'(lockup), 32'h1);
    end

    // Leave LOCK with nonzero seed
    load = 1'b1;
    en   = 1'b0;
    seed = 4'b1000;
    tick();
    chk("unlock_running", 32'(running), 32'h1);
    chk("unlock_lockup",  32'(lockup),  32'h0);
    chk("unlock_q",       32'(q),       32'h8);
    chk("unlock_steps",   32'(steps),   32'h0);

    // Priority: load and en together
    load = 1'b1;
    en   = 1'b1;
    seed = 4'b0110;
    tick();
    chk("prio_q",     32'(q),     32'h6);
    chk("prio_steps", 32'(steps), 32'h0);
    chk("prio_wrap",  32'(wrap),  32'h0);
    load = 1'b0;
    tick();
    chk("prio_step_q",     32'(q),     32'hC);
    chk("prio_step_steps", 32'(steps), 32'h1);

    // Reset mid-run: load 0001, 7 steps, then rst
    load = 1'b1;
    en   = 1'b0;
    seed = 4'b0001;
    tick();
    load = 1'b0;
    en   = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    chk("mid_q",     32'(q),     32'h5);
    chk("mid_steps", 32'(steps), 32'h7);
    en  = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_q",       32'(q),       32'h0);
    chk("midrst_steps",   32'(steps),   32'h0);
    chk("midrst_period",  32'(period),  32'h0);
    chk("midrst_running", 32'(running), 32'h0);
    chk("midrst_lockup",  32'(lockup),  32'h0);
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("idle_q",       32'(q),       32'h0);
      chk("idle_running", 32'(running), 32'h0);
      chk("idle_steps",   32'(steps),   32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lfsr_mux_reg.md
Name: lfsr_mux_reg

Overview:
- Parametrised Fibonacci LFSR for the LFSR project.
- Each state bit is driven by a 2:1 select: parallel seed on load, shifted feedback on step.
- Adds what the single-bit selector cannot: a registered state, a step counter, period measurement and all-zero lock-up detection.
- Serves as the pseudo-random source for downstream test logic.

Parameters:
WIDTH, 4, LFSR state width (>=3)
TAPS, 4'b1001, feedback tap mask; bit i set means q[i] is XORed into feedback (default is x^4+x^3+1, maximal length, period 15)

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  synchronous, active-high reset
load  input  1  capture seed into state this cycle
en  input  1  advance LFSR one step this cycle
seed  input  WIDTH  parallel load value
q  output  WIDTH  current LFSR state (registered)
fb  output  1  feedback bit, combinational: XOR-reduce of (q & TAPS)
running  output  1  high in RUN state
lockup  output  1  high in LOCK state (state is all-zero)
wrap  output  1  one-cycle pulse, registered: state has returned to the loaded seed
steps  output  WIDTH  steps taken since last load or wrap
period  output  WIDTH  last measured period; 0 until the first wrap

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high. No asynchronous paths.
- Reset (rst=1 at a clk edge), overriding all inputs:
  - q=0, steps=0, period=0, wrap=0.
  - Internal seed register = 0.
  - FSM enters IDLE; running=0, lockup=0.
- Step function, shift left: q_next = {q[WIDTH-2:0], fb}.
- FSM states:
  - IDLE: q holds; en ignored.
  - RUN: normal stepping.
  - LOCK: all-zero state; en ignored.
- Load (all states, load=1) has priority over en:
  - q<=seed, seed register <= seed, steps<=0, wrap<=0.
  - Next state is RUN if seed!=0, LOCK if seed==0.
  - period is kept.
- RUN, load=0, en=1:
  - q<=q_next.
  - If q_next==seed register: wrap<=1, period<=steps+1, steps<=0.
  - Otherwise: wrap<=0, steps<=steps+1, wrapping modulo 2^WIDTH.
- RUN, load=0, en=0:
  - q and steps hold; wrap<=0.
- LOCK:
  - q stays 0, lockup=1.
  - Only load with a nonzero seed, or rst, leaves LOCK.
- Latency:
  - q reflects load or step one cycle after the sampling edge.
  - wrap is asserted in the same cycle that q first equals the seed again.
- Simultaneous load and en: load wins. No step occurs and steps=0.
- Reset mid-run: all outputs return to reset values on the next edge; the measured period is discarded.
- A non-maximal TAPS mask gives a shorter cycle; period reports the actual cycle length.

Test Plan:
- Reset: assert rst for 2 cycles with load=1 and seed=4'b0101 -> q=0, steps=0, period=0, running=0, lockup=0.
- Full sequence: load seed=4'b0001, then hold en=1 -> q follows 0011,0111,1111,1110,1101,1010,0101,1011,0110,1100,1001,0010,0100,1000,0001. On the 15th step wrap=1 for exactly one cycle, period=15, steps=0.
- Hold: in RUN, drop en for 3 cycles at q=4'b1110 -> q, steps and period unchanged; wrap=0.
- Lock-up: load seed=0 -> lockup=1, running=0, q=0; en=1 for 5 cycles keeps q=0. Then load 4'b1000 -> running=1, q=4'b1000.
- Priority: load=1 and en=1 together with seed=4'b0110 -> q=4'b0110 (not stepped), steps=0.
- Reset mid-run: after 7 steps from 4'b0001, pulse rst -> q=0, steps=0, period=0, state IDLE. en alone does not change q afterwards.
